fir_coef_sequencer: RTL and testbench
=====================================

FIR_COEF_SEQUENCER -- requirements
Module: fir_coef_sequencer

Interface
REQ-001 The block SHALL have parameter NTAPS, default 7, giving coefficients per set.
REQ-002 The block SHALL have parameter DW, default 8, giving coefficient width.
REQ-003 The block SHALL have parameter NBANKS, default 4, giving stored coefficient sets.
REQ-004 The block SHALL have parameter SETTLE, default 8, giving post-load settle cycles.
REQ-005 The block SHALL have ports: clk input 1, the clock; rst input 1, the reset, which is asynchronous and active-high.
REQ-006 The block SHALL have ports: cfg_wr input 1, bank write strobe; cfg_bank input 2, write bank; cfg_idx input 3, tap index; cfg_data input DW, coefficient.
REQ-007 The block SHALL have ports: load_req input 1, load request level; load_bank input 2, bank to load; abort input 1, cancel load.
REQ-008 The block SHALL have ports: coef_val output DW; writeen output 1; tlast output 1, all driving the filter coefficient port.
REQ-009 The block SHALL have ports: load_ack output 1, acceptance pulse; done output 1, completion pulse; coef_ok output 1, filter output trustworthy; busy output 1; active_bank output 2; cfg_err output 1, rejected-write pulse; load_err output 1, aborted-load pulse.

Function
REQ-010 The state machine SHALL have states IDLE, LOAD, SETTLE; all outputs SHALL be registered.
REQ-011 In IDLE with load_req=1 at an edge, the block SHALL enter LOAD and, in the following cycle, assert load_ack for one cycle, latch active_bank=load_bank, and drive beat 0.
REQ-012 In LOAD, beat k (0..NTAPS-1) SHALL occupy one cycle with writeen=1, coef_val=bank[active_bank][k], tlast=(k==NTAPS-1); beats SHALL be back-to-back without gaps.
REQ-013 After the tlast beat, the block SHALL spend exactly SETTLE cycles in SETTLE with writeen=0, then return to IDLE, pulsing done for one cycle and setting coef_ok=1 in that same cycle.
REQ-014 coef_ok SHALL be 0 from the load_ack cycle until done, and SHALL be 0 after an abort until the next done.
REQ-015 busy SHALL be 1 exactly in LOAD and SETTLE.
REQ-016 A load_req arriving during LOAD or SETTLE SHALL be held in a one-deep pending slot (the latest bank wins) and accepted on the first edge in IDLE.
REQ-017 On abort sampled in LOAD with next beat index <= NTAPS-2, the block SHALL emit one flush beat (writeen=1, tlast=1, coef_val=0), then enter IDLE with a load_err pulse, no done pulse, and a cleared pending slot.
REQ-018 Abort sampled in LOAD with next beat index = NTAPS-1, in SETTLE, or in IDLE SHALL be ignored.
REQ-019 cfg_wr SHALL write bank[cfg_bank][cfg_idx]=cfg_data except in two cases: cfg_idx >= NTAPS, or cfg_bank equals the bank being loaded while in LOAD or on the accepting edge; such writes SHALL be dropped with a one-cycle cfg_err pulse.
REQ-020 Outside LOAD, writeen, tlast and coef_val SHALL be 0.

Reset
REQ-021 rst SHALL force IDLE, clear the pending slot, zero all bank entries, and drive every output to 0 (active_bank=0).
REQ-022 When rst occurs mid-LOAD, writeen SHALL drop immediately; the filter is assumed reset by the same rst.

Structure
REQ-023 Package fir_ctrl_pkg SHALL hold NTAPS, DW, NBANKS, SETTLE defaults and the state encoding.
REQ-024 Bank storage SHALL be a sub-module fir_coef_bank (NBANKS x NTAPS x DW register file with one write port and one read port).

Verification
REQ-025 Scenario 1: write bank1 taps 1..7, then load_req bank1 -> load_ack, then 7 beats coef_val 1..7 with tlast on beat 7; done and coef_ok=1 exactly 9 cycles after the tlast cycle.
REQ-026 Scenario 2: load_req bank2 raised during the SETTLE of a bank1 load -> bank2 load_ack on the first IDLE cycle after done; active_bank=2.
REQ-027 Scenario 3: abort after beat 2 -> flush beat with tlast=1, coef_val=0; load_err pulse; coef_ok=0; no done.
REQ-028 Scenario 4: abort after beat 5 (next index 6) -> ignored; normal tlast beat and done.
REQ-029 Scenario 5: cfg_wr to bank1 during a bank1 load -> cfg_err, bank unchanged; cfg_wr with cfg_idx=7 -> cfg_err.
REQ-030 Scenario 6: rst asserted on beat 3 -> all outputs 0 asynchronously; state IDLE; banks read back 0.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared defaults, address widths and state encoding for the FIR coefficient sequencer.
package fir_ctrl_pkg;

  localparam int NTAPS_DEF  = 7;
  localparam int DW_DEF     = 8;
  localparam int NBANKS_DEF = 4;
  localparam int SETTLE_DEF = 8;

  localparam int BANK_AW = 2;
  localparam int IDX_AW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

  // True when a tap index addresses a real coefficient slot.
  function automatic logic idx_in_range(input logic [IDX_AW-1:0] idx, input int ntaps);
    return ({1'b0, idx} < (IDX_AW + 1)'(ntaps));
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// NBANKS x NTAPS coefficient register file: one synchronous write port, one combinational read port.
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int DW     = DW_DEF,
  parameter int NBANKS = NBANKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [BANK_AW-1:0] i_wbank,
  input  logic [IDX_AW-1:0]  i_widx,
  input  logic [DW-1:0]      i_wdata,
  input  logic [BANK_AW-1:0] i_rbank,
  input  logic [IDX_AW-1:0]  i_ridx,
  output logic [DW-1:0]      o_rdata
);

  logic [DW-1:0] r_mem [NBANKS][NTAPS];
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign w_wr_ok = ({1'b0, i_wbank} < (BANK_AW + 1)'(NBANKS)) && idx_in_range(i_widx, NTAPS);
  assign w_rd_ok = ({1'b0, i_rbank} < (BANK_AW + 1)'(NBANKS)) && idx_in_range(i_ridx, NTAPS);

  // Storage clears on reset so a freshly reset filter never sees stale taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int t = 0; t < NTAPS; t++) begin
          r_mem[b][t] <= '0;
        end
      end
    end else if (i_we && w_wr_ok) begin
      r_mem[i_wbank][i_widx] <= i_wdata;
    end
  end

  // Out-of-range reads return zero rather than an arbitrary entry.
  always_comb begin
    o_rdata = '0;
    if (w_rd_ok) begin
      o_rdata = r_mem[i_rbank][i_ridx];
    end else begin
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/fir_coef_sequencer.sv
// Streams a stored coefficient set into the FIR coefficient port, waits for it to settle,
// and reports whether the filter output can be trusted.
module fir_coef_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int DW     = DW_DEF,
  parameter int NBANKS = NBANKS_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [BANK_AW-1:0] cfg_bank,
  input  logic [IDX_AW-1:0]  cfg_idx,
  input  logic [DW-1:0]      cfg_data,
  input  logic               load_req,
  input  logic [BANK_AW-1:0] load_bank,
  input  logic               abort,
  output logic [DW-1:0]      coef_val,
  output logic               writeen,
  output logic               tlast,
  output logic               load_ack,
  output logic               done,
  output logic               coef_ok,
  output logic               busy,
  output logic [BANK_AW-1:0] active_bank,
  output logic               cfg_err,
  output logic               load_err
);

  localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_AW-1:0] LP_LAST     = IDX_AW'(NTAPS - 1);
  localparam logic [CW-1:0]     LP_SET_LAST = CW'(SETTLE - 1);

  seq_state_e         r_state;
  logic [IDX_AW-1:0]  r_beat;
  logic [CW-1:0]      r_cnt;
  logic               r_flush;
  logic               r_pend;
  logic [BANK_AW-1:0] r_pend_bank;

  logic [DW-1:0]      r_coef_val;
  logic               r_writeen;
  logic               r_tlast;
  logic               r_load_ack;
  logic               r_done;
  logic               r_coef_ok;
  logic               r_busy;
  logic [BANK_AW-1:0] r_active_bank;
  logic               r_cfg_err;
  logic               r_load_err;

  seq_state_e         w_state_nx;
  logic [IDX_AW-1:0]  w_beat_nx;
  logic [CW-1:0]      w_cnt_nx;
  logic               w_flush_nx;
  logic               w_pend_nx;
  logic [BANK_AW-1:0] w_pend_bank_nx;
  logic [BANK_AW-1:0] w_bank_nx;
  logic               w_we_nx;
  logic               w_tlast_nx;
  logic               w_ack_nx;
  logic               w_done_nx;
  logic               w_ok_nx;
  logic               w_lerr_nx;
  logic               w_accept;
  logic [BANK_AW-1:0] w_req_bank;
  logic               w_abort_ok;
  logic               w_cfg_bad;
  logic               w_mem_we;
  logic [DW-1:0]      w_rdata;

  // A live request beats the parked one so the latest bank always wins.
  assign w_req_bank = load_req ? load_bank : r_pend_bank;
  // Abort is honoured only while at least one ordinary beat would still follow the next one.
  assign w_abort_ok = ({1'b0, r_beat} + (IDX_AW + 1)'(2)) <= {1'b0, LP_LAST};
  assign w_cfg_bad  = !idx_in_range(cfg_idx, NTAPS)
                    || ((r_state == ST_LOAD) && (cfg_bank == r_active_bank))
                    || (w_accept && (cfg_bank == w_req_bank));
  assign w_mem_we   = cfg_wr && !w_cfg_bad;

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .DW     (DW),
    .NBANKS (NBANKS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_wbank (cfg_bank),
    .i_widx  (cfg_idx),
    .i_wdata (cfg_data),
    .i_rbank (w_bank_nx),
    .i_ridx  (w_beat_nx),
    .o_rdata (w_rdata)
  );

  // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_nx     = r_state;
    w_beat_nx      = r_beat;
    w_cnt_nx       = r_cnt;
    w_flush_nx     = 1'b0;
    w_pend_nx      = r_pend;
    w_pend_bank_nx = r_pend_bank;
    w_bank_nx      = r_active_bank;
    w_we_nx        = 1'b0;
    w_tlast_nx     = 1'b0;
    w_ack_nx       = 1'b0;
    w_done_nx      = 1'b0;
    w_ok_nx        = r_coef_ok;
    w_lerr_nx      = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_req || r_pend) begin
          w_accept   = 1'b1;
          w_state_nx = ST_LOAD;
          w_beat_nx  = '0;
          w_bank_nx  = w_req_bank;
          w_pend_nx  = 1'b0;
          w_ack_nx   = 1'b1;
          w_ok_nx    = 1'b0;
          w_we_nx    = 1'b1;
          w_tlast_nx = (LP_LAST == '0);
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (r_flush) begin
          w_state_nx = ST_IDLE;
          w_beat_nx  = '0;
          w_pend_nx  = 1'b0;
          w_lerr_nx  = 1'b1;
        end else if (abort && w_abort_ok) begin
          w_flush_nx = 1'b1;
          w_we_nx    = 1'b1;
          w_tlast_nx = 1'b1;
          w_pend_nx  = 1'b0;
        end else begin
          if (load_req) begin
            w_pend_nx      = 1'b1;
            w_pend_bank_nx = load_bank;
          end else begin
            w_pend_nx = r_pend;
          end
          if (r_beat == LP_LAST) begin
            w_state_nx = ST_SETTLE;
            w_cnt_nx   = '0;
          end else begin
            w_beat_nx  = r_beat + IDX_AW'(1);
            w_we_nx    = 1'b1;
            w_tlast_nx = (w_beat_nx == LP_LAST);
          end
        end
      end
      ST_SETTLE: begin
        if (load_req) begin
          w_pend_nx      = 1'b1;
          w_pend_bank_nx = load_bank;
        end else begin
          w_pend_nx = r_pend;
        end
        if (r_cnt == LP_SET_LAST) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
          w_ok_nx    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_pend_nx  = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_cnt       <= '0;
      r_flush     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_bank <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_beat      <= w_beat_nx;
      r_cnt       <= w_cnt_nx;
      r_flush     <= w_flush_nx;
      r_pend      <= w_pend_nx;
      r_pend_bank <= w_pend_bank_nx;
    end
  end

  // Output register; the flush beat carries zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coef_val    <= '0;
      r_writeen     <= 1'b0;
      r_tlast       <= 1'b0;
      r_load_ack    <= 1'b0;
      r_done        <= 1'b0;
      r_coef_ok     <= 1'b0;
      r_busy        <= 1'b0;
      r_active_bank <= '0;
      r_cfg_err     <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_coef_val    <= (w_we_nx && !w_flush_nx) ? w_rdata : '0;
      r_writeen     <= w_we_nx;
      r_tlast       <= w_tlast_nx;
      r_load_ack    <= w_ack_nx;
      r_done        <= w_done_nx;
      r_coef_ok     <= w_ok_nx;
      r_busy        <= (w_state_nx != ST_IDLE);
      r_active_bank <= w_bank_nx;
      r_cfg_err     <= cfg_wr && w_cfg_bad;
      r_load_err    <= w_lerr_nx;
    end
  end

  assign coef_val    = r_coef_val;
  assign writeen     = r_writeen;
  assign tlast       = r_tlast;
  assign load_ack    = r_load_ack;
  assign done        = r_done;
  assign coef_ok     = r_coef_ok;
  assign busy        = r_busy;
  assign active_bank = r_active_bank;
  assign cfg_err     = r_cfg_err;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed plus randomized bench for fir_coef_sequencer with a cycle-level expectation model.
module tb_fir_coef_sequencer;

  localparam int NTAPS  = 7;
  localparam int SETTLE = 8;

  logic       clk;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_bank;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_data;
  logic       load_req;
  logic [1:0] load_bank;
  logic       abort;
  logic [7:0] coef_val;
  logic       writeen, tlast, load_ack, done, coef_ok, busy, cfg_err, load_err;
  logic [1:0] active_bank;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [4][NTAPS];
  logic       m_ok;
  logic [1:0] m_ab;

  fir_coef_sequencer dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_bank(cfg_bank), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .load_req(load_req), .load_bank(load_bank), .abort(abort),
    .coef_val(coef_val), .writeen(writeen), .tlast(tlast), .load_ack(load_ack),
    .done(done), .coef_ok(coef_ok), .busy(busy), .active_bank(active_bank),
    .cfg_err(cfg_err), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {14'd0, load_ack, writeen, tlast, busy, coef_ok, done, load_err, cfg_err, active_bank, coef_val};
  endfunction

  function automatic logic [31:0] ev(input bit ack, input bit we, input bit tl, input bit bz,
                                     input bit ok, input bit dn, input bit le, input bit ce,
                                     input logic [1:0] ab, input logic [7:0] cv);
    return {14'd0, ack, we, tl, bz, ok, dn, le, ce, ab, cv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int b, input int idx, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_bank = 2'(b); cfg_idx = 3'(idx); cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk($sformatf("cfg_wr b%0d i%0d", b, idx), outs(), ev(0, 0, 0, 0, m_ok, 0, 0, idx >= NTAPS, m_ab, 8'd0));
    if (idx < NTAPS) mdl[b][idx] = d;
  endtask

  // One complete load as seen at the coefficient port; optional abort, parked request and mid-load write.
  task automatic do_load(input int b, input bit req, input int abort_at, input int pend_b,
                         input int pend_at, input int cfg_b);
    bit         ce_exp;
    int         ci;
    logic [7:0] cd;
    if (req) begin load_req = 1'b1; load_bank = 2'(b); end
    @(negedge clk);
    load_req = 1'b0;
    m_ab = 2'(b);
    m_ok = 1'b0;
    ce_exp = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      chk($sformatf("beat%0d bank%0d", k, b), outs(),
          ev(k == 0, 1, k == NTAPS - 1, 1, 0, 0, 0, ce_exp, m_ab, mdl[b][k]));
      ce_exp = 1'b0;
      cfg_wr = 1'b0;
      if (k == pend_at) begin load_req = 1'b1; load_bank = 2'(pend_b); end
      else load_req = 1'b0;
      if (k == 3 && cfg_b >= 0) begin
        ci = $urandom_range(0, NTAPS - 1);
        cd = 8'($urandom);
        cfg_wr = 1'b1; cfg_bank = 2'(cfg_b); cfg_idx = 3'(ci); cfg_data = cd;
        ce_exp = (cfg_b == b);
        if (!ce_exp) mdl[cfg_b][ci] = cd;
      end
      abort = (k == abort_at);
      @(negedge clk);
      abort = 1'b0;
      if (k == abort_at && k + 1 <= NTAPS - 2) begin
        cfg_wr = 1'b0;
        load_req = 1'b0;
        chk("flush beat", outs(), ev(0, 1, 1, 1, 0, 0, 0, ce_exp, m_ab, 8'd0));
        @(negedge clk);
        chk("abort load_err", outs(), ev(0, 0, 0, 0, 0, 0, 1, 0, m_ab, 8'd0));
        repeat (2) begin
          @(negedge clk);
          chk("abort idle", outs(), ev(0, 0, 0, 0, 0, 0, 0, 0, m_ab, 8'd0));
        end
        return;
      end
    end
    for (int s = 0; s < SETTLE; s++) begin
      chk($sformatf("settle%0d", s), outs(), ev(0, 0, 0, 1, 0, 0, 0, ce_exp, m_ab, 8'd0));
      ce_exp = 1'b0;
      cfg_wr = 1'b0;
      if (NTAPS + s == pend_at) begin load_req = 1'b1; load_bank = 2'(pend_b); end
      else load_req = 1'b0;
      @(negedge clk);
    end
    load_req = 1'b0;
    m_ok = 1'b1;
    chk("done", outs(), ev(0, 0, 0, 0, 1, 1, 0, 0, m_ab, 8'd0));
  endtask

  initial begin
    int a;
    int cb;
    rst = 1'b1; cfg_wr = 1'b0; cfg_bank = 2'd0; cfg_idx = 3'd0; cfg_data = 8'd0;
    load_req = 1'b0; load_bank = 2'd0; abort = 1'b0;
    m_ok = 1'b0; m_ab = 2'd0;
    for (int b = 0; b < 4; b++) for (int t = 0; t < NTAPS; t++) mdl[b][t] = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset outputs", outs(), 32'd0);
    rst = 1'b0;

    // Bank1 = 1..7, others random; plain load of bank1
    for (int i = 0; i < NTAPS; i++) cfg_write(1, i, 8'(i + 1));
    for (int b = 0; b < 4; b++)
      if (b != 1) for (int i = 0; i < NTAPS; i++) cfg_write(b, i, 8'($urandom));
    do_load(1, 1, -1, -1, -1, -1);

    // Request for bank2 parked during settle, accepted after done
    do_load(1, 1, -1, 2, NTAPS + 3, -1);
    do_load(2, 0, -1, -1, -1, -1);

    // Early abort flushes; a request parked before the abort is discarded
    do_load(3, 1, 2, -1, -1, -1);
    do_load(0, 1, 2, 1, 1, -1);
    // Late abort is ignored
    do_load(0, 1, 5, -1, -1, -1);

    // Writes to the loading bank are refused, others go through; bad index refused
    do_load(1, 1, -1, -1, -1, 1);
    do_load(1, 1, -1, -1, -1, 2);
    do_load(2, 1, -1, -1, -1, -1);
    cfg_write(1, 7, 8'hAA);
    do_load(1, 1, -1, -1, -1, -1);

    for (int n = 0; n < 10; n++) begin
      a  = $urandom_range(0, 6);
      cb = $urandom_range(0, 4);
      if (a == 6) a = -1;
      cfg_write($urandom_range(0, 3), $urandom_range(0, 7), 8'($urandom));
      do_load($urandom_range(0, 3), 1, a, -1, -1, cb - 1);
    end

    // Reset in the middle of a load
    load_req = 1'b1; load_bank = 2'd1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset beat3", outs(), ev(0, 1, 0, 1, 0, 0, 0, 0, 2'd1, mdl[1][3]));
    rst = 1'b1;
    #1;
    chk("async reset outputs", outs(), 32'd0);
    for (int b = 0; b < 4; b++) for (int t = 0; t < NTAPS; t++) mdl[b][t] = 8'd0;
    m_ok = 1'b0; m_ab = 2'd0;
    @(negedge clk);
    chk("held reset outputs", outs(), 32'd0);
    rst = 1'b0;
    do_load(1, 1, -1, -1, -1, -1);
    do_load(3, 1, -1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
